// File: rtl/mdu_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: shadows MDU occupancy with a
// latency counter and stalls MD-class ops. Optional shadow/MDU agreement check: MDU_ISSUE_CHECK_EN.
`ifndef MDUOP_SIZE
`define MDUOP_SIZE  4
`define MDUOP_NOOP  4'd0
`define MDUOP_MULT  4'd1
`define MDUOP_MULTU 4'd2
`define MDUOP_DIV   4'd3
`define MDUOP_DIVU  4'd4
`define MDUOP_MFHI  4'd5
`define MDUOP_MFLO  4'd6
`define MDUOP_MTHI  4'd7
`define MDUOP_MTLO  4'd8
`endif

module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic [`MDUOP_SIZE-1:0] ex_op,
  input  logic [31:0]            ex_rs,
  input  logic [31:0]            ex_rt,
  input  logic                   flush,
  input  logic                   mdu_busy,
  input  logic [31:0]            mdu_hi,
  input  logic [31:0]            mdu_lo,
`ifdef MDU_ISSUE_CHECK_EN
  output logic                   err,
`endif
  output logic [`MDUOP_SIZE-1:0] mdu_op,
  output logic [31:0]            mdu_opnd1,
  output logic [31:0]            mdu_opnd2,
  output logic                   stall,
  output logic [31:0]            rd_data
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             md_s;
  logic             stall_s;
  logic             issue_s;
  logic             is_mul_s;
  logic             is_div_s;

  function automatic logic is_md(input logic [`MDUOP_SIZE-1:0] op);
    case (op)
      `MDUOP_MULT, `MDUOP_MULTU, `MDUOP_DIV, `MDUOP_DIVU,
      `MDUOP_MFHI, `MDUOP_MFLO, `MDUOP_MTHI, `MDUOP_MTLO: is_md = 1'b1;
      default:                                            is_md = 1'b0;
    endcase
  endfunction

  // Stall/issue decision; non-MD ops never wait on the MDU
  always_comb begin
    md_s     = is_md(ex_op);
    stall_s  = ex_valid & md_s & (state_r != IDLE);
    issue_s  = ex_valid & md_s & ~stall_s & ~flush;
    is_mul_s = (ex_op == `MDUOP_MULT) | (ex_op == `MDUOP_MULTU);
    is_div_s = (ex_op == `MDUOP_DIV)  | (ex_op == `MDUOP_DIVU);
  end

  assign stall     = stall_s;
  assign mdu_op    = issue_s ? ex_op : `MDUOP_NOOP;
  assign mdu_opnd1 = ex_rs;
  assign mdu_opnd2 = ex_rt;

  // HI/LO read-back for mfhi/mflo
  always_comb begin
    case (ex_op)
      `MDUOP_MFHI: rd_data = mdu_hi;
      `MDUOP_MFLO: rd_data = mdu_lo;
      default:     rd_data = 32'd0;
    endcase
  end

  // Occupancy FSM: counts down the MDU latency after a mul/div issue
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s && is_mul_s) begin
            state_r <= MUL_WAIT;
            cnt_r   <= CNT_W'(MULT_LAT);
          end else if (issue_s && is_div_s) begin
            state_r <= DIV_WAIT;
            cnt_r   <= CNT_W'(DIV_LAT);
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if (cnt_r == CNT_W'(1)) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef MDU_ISSUE_CHECK_EN
  logic err_r;

  // Sticky flag: shadow occupancy and MDU busy disagree
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if ((state_r != IDLE) != mdu_busy) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic unused_busy_s;
  assign unused_busy_s = mdu_busy;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU (latency, HI/LO, busy).
`ifndef MDUOP_SIZE
`define MDUOP_SIZE  4
`define MDUOP_NOOP  4'd0
`define MDUOP_MULT  4'd1
`define MDUOP_MULTU 4'd2
`define MDUOP_DIV   4'd3
`define MDUOP_DIVU  4'd4
`define MDUOP_MFHI  4'd5
`define MDUOP_MFLO  4'd6
`define MDUOP_MTHI  4'd7
`define MDUOP_MTLO  4'd8
`endif

module tb_mdu_issue_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ex_valid;
  logic [`MDUOP_SIZE-1:0] ex_op;
  logic [31:0]            ex_rs, ex_rt;
  logic                   flush;
  logic                   mdu_busy;
  logic [31:0]            mdu_hi, mdu_lo;
  logic [`MDUOP_SIZE-1:0] mdu_op;
  logic [31:0]            mdu_opnd1, mdu_opnd2, rd_data;
  logic                   stall;
`ifdef MDU_ISSUE_CHECK_EN
  logic                   err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [`MDUOP_SIZE-1:0] op;
    logic [31:0]            a;
    logic [31:0]            b;
    logic                   chk_rd;
    logic [31:0]            rd;
    int                     stalls;
  } exp_t;
  exp_t sb_q[$];

  mdu_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .flush(flush), .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
`ifdef MDU_ISSUE_CHECK_EN
    .err(err),
`endif
    .mdu_op(mdu_op), .mdu_opnd1(mdu_opnd1), .mdu_opnd2(mdu_opnd2), .stall(stall),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural MDU: results commit when the latency expires
  int          m_cnt;
  logic [31:0] m_phi, m_plo;
  logic        force_idle = 1'b0;
  assign mdu_busy = (m_cnt != 0) & ~force_idle;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; mdu_hi <= 32'd0; mdu_lo <= 32'd0;
    end else begin
      if (m_cnt == 1) begin
        mdu_hi <= m_phi; mdu_lo <= m_plo;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      case (mdu_op)
        `MDUOP_MULT, `MDUOP_MULTU: begin
          {m_phi, m_plo} <= {32'd0, mdu_opnd1} * {32'd0, mdu_opnd2};
          m_cnt <= MULT_LAT;
        end
        `MDUOP_DIV, `MDUOP_DIVU: begin
          m_plo <= mdu_opnd1 / mdu_opnd2; m_phi <= mdu_opnd1 % mdu_opnd2;
          m_cnt <= DIV_LAT;
        end
        `MDUOP_MTHI: mdu_hi <= mdu_opnd1;
        `MDUOP_MTLO: mdu_lo <= mdu_opnd1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every issue and checks stall history
  int stall_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (mdu_op !== `MDUOP_NOOP) begin
          if (sb_q.size() == 0) begin
            check("unexpected_issue", 32'(mdu_op), 32'(`MDUOP_NOOP));
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("issue_op", 32'(mdu_op), 32'(e.op));
            check("opnd1", mdu_opnd1, e.a);
            check("opnd2", mdu_opnd2, e.b);
            check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            if (e.chk_rd) check("rd_data", rd_data, e.rd);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Present an op until it issues; expected response goes to the scoreboard first
  task automatic issue(input logic [`MDUOP_SIZE-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic chk_rd, input logic [31:0] rd,
                       input int stalls);
    exp_t e;
    bit   ok = 0;
    e.op = op; e.a = a; e.b = b; e.chk_rd = chk_rd; e.rd = rd; e.stalls = stalls;
    sb_q.push_back(e);
    ex_valid = 1'b1; ex_op = op; ex_rs = a; ex_rt = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1; break; end
    end
    if (!ok) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = `MDUOP_NOOP;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_op = `MDUOP_NOOP; ex_rs = 32'd0; ex_rt = 32'd0;
    flush = 1'b0;
    idle(3);
    ex_valid = 1'b1; ex_op = `MDUOP_MFHI;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
`ifdef MDU_ISSUE_CHECK_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    ex_valid = 1'b0; ex_op = `MDUOP_NOOP;
    @(negedge clk);
    check("reset_mdu_op", 32'(mdu_op), 32'(`MDUOP_NOOP));
    @(posedge clk); #1 reset = 1'b0;
    idle(2);

    // 1) mult 3*4 then mflo
    issue(`MDUOP_MULT, 32'd3, 32'd4, 1'b0, 32'd0, 0);
    issue(`MDUOP_MFLO, 32'd0, 32'd0, 1'b1, 32'd12, MULT_LAT);
    idle(2);

    // 2) div 7/2, one non-MD cycle inside the wait, then mfhi, mflo
    issue(`MDUOP_DIV, 32'd7, 32'd2, 1'b0, 32'd0, 0);
    ex_valid = 1'b1; ex_op = `MDUOP_NOOP;
    @(negedge clk);
    check("non_md_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    issue(`MDUOP_MFHI, 32'd0, 32'd0, 1'b1, 32'd1, DIV_LAT - 1);
    issue(`MDUOP_MFLO, 32'd0, 32'd0, 1'b1, 32'd3, 0);
    idle(2);

    // 3) mthi / mtlo in idle, read back on the following cycle
    issue(`MDUOP_MTHI, 32'h1234, 32'd0, 1'b0, 32'd0, 0);
    issue(`MDUOP_MFHI, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 0);
    issue(`MDUOP_MTLO, 32'h00AB_CDEF, 32'd0, 1'b0, 32'd0, 0);
    issue(`MDUOP_MFLO, 32'd0, 32'd0, 1'b1, 32'h00AB_CDEF, 0);
    idle(2);

    // 4) flushed mult is dropped
    ex_valid = 1'b1; ex_op = `MDUOP_MULT; ex_rs = 32'd5; ex_rt = 32'd6; flush = 1'b1;
    @(negedge clk);
    check("flush_mdu_op", 32'(mdu_op), 32'(`MDUOP_NOOP));
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; ex_op = `MDUOP_NOOP;
    issue(`MDUOP_MFLO, 32'd0, 32'd0, 1'b1, 32'h00AB_CDEF, 0);
    idle(2);

    // 5) reset in the cycle where the div counter reads 3
    issue(`MDUOP_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 0);
    ex_valid = 1'b1; ex_op = `MDUOP_MFHI;
    @(negedge clk);
    check("div_wait_stall", 32'(stall), 32'd1);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1; ex_valid = 1'b0; ex_op = `MDUOP_NOOP;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_mdu_op", 32'(mdu_op), 32'(`MDUOP_NOOP));
    ex_valid = 1'b1; ex_op = `MDUOP_MFHI;
    #1;
    check("post_reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 ex_valid = 1'b0; ex_op = `MDUOP_NOOP;
    issue(`MDUOP_MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    idle(2);

`ifdef MDU_ISSUE_CHECK_EN
    // 6) MDU drops busy on the 2nd wait cycle
    issue(`MDUOP_MULT, 32'd2, 32'd2, 1'b0, 32'd0, 0);
    @(negedge clk);
    check("err_clean", 32'(err), 32'd0);
    @(posedge clk); #1 force_idle = 1'b1;
    @(posedge clk); #1 force_idle = 1'b0;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    idle(8);
    check("err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    idle(2);
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
